// File: rtl/sh7604_mac_issue_pkg.sv
// Shared types for the SH7604 CPU-to-multiplier command issuer.
// Op encodings, issuer states and the decoded-op record.
package sh7604_mac_issue_pkg;

   typedef enum logic [3:0] {
      OP_STS    = 4'b0000,
      OP_MULL   = 4'b0001,
      OP_DMULU  = 4'b0010,
      OP_DMULS  = 4'b0011,
      OP_LDS    = 4'b0100,
      OP_MULUW  = 4'b0110,
      OP_MULSW  = 4'b0111,
      OP_LDSM   = 4'b1000,
      OP_MACL   = 4'b1001,
      OP_MACW   = 4'b1011,
      OP_CLRMAC = 4'b1111
   } MacOp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      RD,
      ACKS
   } MacIssSt_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_MACL = 2'b01;
   localparam logic [1:0] SEL_MACH = 2'b10;

   // mem_op marks MAC.L/MAC.W: those carry addresses and the saturation flag.
   typedef struct packed {
      logic       needs_a;
      logic       needs_b;
      logic       is_read;
      logic [1:0] sel_b;
      logic       pack_w;
      logic       mem_op;
   } MacDec_t;

   function automatic logic [31:0] packWord(input logic [15:0] lo, input logic [15:0] hi);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/sh7604_mac_opdec.sv
// Combinational op decoder: maps a MAC-class op code onto the bus steps it needs
// and the select used for its final write.
module sh7604_mac_opdec
   import sh7604_mac_issue_pkg::*;
(
   input  logic [3:0] i_op,
   input  logic [1:0] i_dst,
   output MacDec_t    o_dec
);

   always_comb begin
      o_dec = '0;
      case (i_op)
         OP_STS: begin
            o_dec.is_read = 1'b1;
         end
         OP_MULL, OP_DMULU, OP_DMULS: begin
            o_dec.needs_a = 1'b1;
            o_dec.needs_b = 1'b1;
            o_dec.sel_b   = SEL_MACH;
         end
         OP_LDS, OP_LDSM: begin
            o_dec.needs_b = 1'b1;
            o_dec.sel_b   = i_dst;
         end
         OP_MULUW, OP_MULSW: begin
            o_dec.needs_b = 1'b1;
            o_dec.sel_b   = SEL_MACH;
            o_dec.pack_w  = 1'b1;
         end
         OP_MACL, OP_MACW: begin
            o_dec.needs_a = 1'b1;
            o_dec.needs_b = 1'b1;
            o_dec.sel_b   = SEL_MACH;
            o_dec.mem_op  = 1'b1;
         end
         OP_CLRMAC: begin
            o_dec.needs_b = 1'b1;
            o_dec.sel_b   = SEL_MACL;
         end
         default: begin
            o_dec = '0;
         end
      endcase
   end

endmodule

// File: rtl/sh7604_mac_issue.sv
// Initiator side of the SH7604 CPU-to-multiplier command port: sequences one
// MAC-class op onto the multiplier bus and returns a single ACK strobe.
module sh7604_mac_issue
   import sh7604_mac_issue_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ce_r,
   input  logic        i_en,
   input  logic        i_req,
   input  logic [3:0]  i_op,
   input  logic        i_sat,
   input  logic [1:0]  i_dst,
   input  logic [31:0] i_opa,
   input  logic [31:0] i_opb,
   input  logic [31:0] i_addra,
   input  logic [31:0] i_addrb,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic [1:0]  o_mac_sel,
   output logic [3:0]  o_mac_op,
   output logic        o_mac_s,
   output logic        o_mac_we,
   output logic [31:0] o_mac_a,
   output logic [31:0] o_mac_do,
   input  logic [31:0] i_mac_di,
   input  logic        i_mac_busy
);

   MacIssSt_t   r_state, w_nxt_state;
   MacDec_t     w_dec;

   logic        r_ack, w_nxt_ack;
   logic [31:0] r_rdata, w_nxt_rdata;
   logic [1:0]  r_sel, w_nxt_sel;
   logic [3:0]  r_op, w_nxt_op;
   logic        r_s, w_nxt_s;
   logic [31:0] r_a, w_nxt_a;
   logic [31:0] r_do, w_nxt_do;
   logic        r_we, w_nxt_we;
   logic [1:0]  r_b_sel, w_nxt_b_sel;
   logic [31:0] r_b_a, w_nxt_b_a;
   logic [31:0] r_b_do, w_nxt_b_do;

   logic        w_step;
   logic        w_wr_done;
   logic [31:0] w_b_a;
   logic [31:0] w_b_do;

   sh7604_mac_opdec u_opdec (
      .i_op  (i_op),
      .i_dst (i_dst),
      .o_dec (w_dec)
   );

   assign w_step    = i_ce_r & i_en;
   assign w_wr_done = w_step & r_we & ~i_mac_busy;

   // Final-write payload is fixed at accept time, so operands need not be held by the pipeline.
   assign w_b_a  = w_dec.mem_op ? i_addrb : '0;
   assign w_b_do = w_dec.pack_w  ? packWord(i_opa[15:0], i_opb[15:0]) :
                   w_dec.needs_a ? i_opb : i_opa;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ack   = r_ack;
      w_nxt_rdata = r_rdata;
      w_nxt_sel   = r_sel;
      w_nxt_op    = r_op;
      w_nxt_s     = r_s;
      w_nxt_a     = r_a;
      w_nxt_do    = r_do;
      w_nxt_we    = r_we;
      w_nxt_b_sel = r_b_sel;
      w_nxt_b_a   = r_b_a;
      w_nxt_b_do  = r_b_do;

      case (r_state)
         IDLE: begin
            if (w_step && i_req) begin
               w_nxt_op    = i_op;
               w_nxt_s     = w_dec.mem_op & i_sat;
               w_nxt_b_sel = w_dec.sel_b;
               w_nxt_b_a   = w_b_a;
               w_nxt_b_do  = w_b_do;
               if (w_dec.needs_a) begin
                  w_nxt_state = WR_A;
                  w_nxt_sel   = SEL_MACL;
                  w_nxt_a     = w_dec.mem_op ? i_addra : '0;
                  w_nxt_do    = i_opa;
                  w_nxt_we    = 1'b1;
               end else if (w_dec.needs_b) begin
                  w_nxt_state = WR_B;
                  w_nxt_sel   = w_dec.sel_b;
                  w_nxt_a     = w_b_a;
                  w_nxt_do    = w_b_do;
                  w_nxt_we    = 1'b1;
               end else if (w_dec.is_read) begin
                  w_nxt_state = RD;
                  w_nxt_sel   = i_dst;
                  w_nxt_a     = '0;
                  w_nxt_do    = '0;
                  w_nxt_we    = 1'b0;
               end else begin
                  w_nxt_state = ACKS;
                  w_nxt_ack   = 1'b1;
                  w_nxt_op    = '0;
                  w_nxt_s     = 1'b0;
               end
            end
         end
         WR_A: begin
            if (w_wr_done) begin
               w_nxt_state = WR_B;
               w_nxt_sel   = r_b_sel;
               w_nxt_a     = r_b_a;
               w_nxt_do    = r_b_do;
            end
         end
         WR_B: begin
            if (w_wr_done) begin
               w_nxt_state = ACKS;
               w_nxt_ack   = 1'b1;
               w_nxt_sel   = SEL_NONE;
               w_nxt_op    = '0;
               w_nxt_s     = 1'b0;
               w_nxt_a     = '0;
               w_nxt_do    = '0;
               w_nxt_we    = 1'b0;
            end
         end
         RD: begin
            if (w_step && !i_mac_busy) begin
               w_nxt_state = ACKS;
               w_nxt_ack   = 1'b1;
               w_nxt_rdata = i_mac_di;
               w_nxt_sel   = SEL_NONE;
               w_nxt_op    = '0;
            end
         end
         ACKS: begin
            if (w_step) begin
               w_nxt_state = IDLE;
               w_nxt_ack   = 1'b0;
            end
         end
         default: begin
            w_nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_sel   <= SEL_NONE;
         r_op    <= '0;
         r_s     <= 1'b0;
         r_a     <= '0;
         r_do    <= '0;
         r_we    <= 1'b0;
         r_b_sel <= SEL_NONE;
         r_b_a   <= '0;
         r_b_do  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_ack   <= w_nxt_ack;
         r_rdata <= w_nxt_rdata;
         r_sel   <= w_nxt_sel;
         r_op    <= w_nxt_op;
         r_s     <= w_nxt_s;
         r_a     <= w_nxt_a;
         r_do    <= w_nxt_do;
         r_we    <= w_nxt_we;
         r_b_sel <= w_nxt_b_sel;
         r_b_a   <= w_nxt_b_a;
         r_b_do  <= w_nxt_b_do;
      end
   end

   // Select stays driven under BUSY; only the strobe is withheld.
   assign o_mac_we  = r_we & i_en & ~i_mac_busy;
   assign o_ack     = r_ack;
   assign o_rdata   = r_rdata;
   assign o_mac_sel = r_sel;
   assign o_mac_op  = r_op;
   assign o_mac_s   = r_s;
   assign o_mac_a   = r_a;
   assign o_mac_do  = r_do;

endmodule

// File: tb/tb_sh7604_mac_issue.sv
// Directed bench for sh7604_mac_issue: a small multiplier model answers reads,
// bus writes and read data are scoreboarded against queued expectations.
module tb_sh7604_mac_issue;

   typedef struct packed {
      logic [1:0]  sel;
      logic [3:0]  op;
      logic        s;
      logic [31:0] a;
      logic [31:0] d;
   } WrExp_t;

   logic        clock = 1'b0;
   logic        rstN = 1'b0;
   logic        ceR = 1'b1;
   logic        en = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  op = '0;
   logic        sat = 1'b0;
   logic [1:0]  dst = '0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic [31:0] addrA = '0;
   logic [31:0] addrB = '0;
   logic        busy = 1'b0;
   logic [31:0] macDi;

   logic        ack;
   logic [31:0] rdata;
   logic [1:0]  macSel;
   logic [3:0]  macOp;
   logic        macS;
   logic        macWe;
   logic [31:0] macA;
   logic [31:0] macDo;

   WrExp_t      wrQ[$];
   logic [31:0] rdQ[$];
   WrExp_t      monE;

   int checks = 0;
   int passed = 0;
   int fails = 0;

   int          busyLeft = 0;
   int          enLowLeft = 0;
   int          ceLowLeft = 0;
   logic [1:0]  busySel = 2'b01;
   logic [1:0]  enSel = 2'b01;
   logic [1:0]  ceSel = 2'b10;

   logic [31:0] mach = '0;
   logic [31:0] macl = '0;
   logic [31:0] ma = '0;
   logic [31:0] maA = '0;
   logic [31:0] lastRd = '0;

   sh7604_mac_issue dut (
      .i_clk      (clock),
      .i_rst_n    (rstN),
      .i_ce_r     (ceR),
      .i_en       (en),
      .i_req      (req),
      .i_op       (op),
      .i_sat      (sat),
      .i_dst      (dst),
      .i_opa      (opa),
      .i_opb      (opb),
      .i_addra    (addrA),
      .i_addrb    (addrB),
      .o_ack      (ack),
      .o_rdata    (rdata),
      .o_mac_sel  (macSel),
      .o_mac_op   (macOp),
      .o_mac_s    (macS),
      .o_mac_we   (macWe),
      .o_mac_a    (macA),
      .o_mac_do   (macDo),
      .i_mac_di   (macDi),
      .i_mac_busy (busy)
   );

   assign macDi = (macSel == 2'b10) ? mach : macl;

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] sx16(input logic [15:0] v);
      return {{48{v[15]}}, v};
   endfunction

   // Behavioural multiplier: updates MACH/MACL from committed bus writes.
   task automatic modelWrite(input logic [1:0] sel, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
      logic [63:0] p;
      logic [15:0] wa;
      logic [15:0] wb;
      case (o)
         4'h4, 4'h8: if (sel == 2'b01) macl = d; else mach = d;
         4'hF: begin mach = '0; macl = '0; end
         4'h1: if (sel == 2'b01) ma = d; else macl = ma * d;
         4'h2: if (sel == 2'b01) ma = d; else begin p = {32'b0, ma} * {32'b0, d}; {mach, macl} = p; end
         4'h3: if (sel == 2'b01) ma = d; else begin p = sx32(ma) * sx32(d); {mach, macl} = p; end
         4'h6: macl = {16'b0, d[15:0]} * {16'b0, d[31:16]};
         4'h7: begin p = sx16(d[15:0]) * sx16(d[31:16]); macl = p[31:0]; end
         4'h9: if (sel == 2'b01) ma = d; else begin p = sx32(ma) * sx32(d); {mach, macl} = {mach, macl} + p; end
         4'hB: begin
            if (sel == 2'b01) begin
               ma = d;
               maA = a;
            end else begin
               wa = maA[1] ? ma[15:0] : ma[31:16];
               wb = a[1] ? d[15:0] : d[31:16];
               p = sx16(wa) * sx16(wb);
               {mach, macl} = {mach, macl} + p;
            end
         end
         default: begin end
      endcase
   endtask

   task automatic pushWrite(input logic [1:0] sel, input logic [3:0] o, input logic s, input logic [31:0] a, input logic [31:0] d);
      WrExp_t e;
      e.sel = sel;
      e.op = o;
      e.s = s;
      e.a = a;
      e.d = d;
      wrQ.push_back(e);
   endtask

   // Drives BUSY/EN/CE_R disturbances, then checks each committed write against the queue.
   always begin
      @(negedge clock);
      if (busyLeft > 0 && macSel == busySel) begin busy = 1'b1; busyLeft--; end else busy = 1'b0;
      if (enLowLeft > 0 && macSel == enSel) begin en = 1'b0; enLowLeft--; end else en = 1'b1;
      if (ceLowLeft > 0 && macSel == ceSel) begin ceR = 1'b0; ceLowLeft--; end else ceR = 1'b1;
      #1;
      if (rstN) begin
         if (!en) checkOutput("we_en_low", 64'(macWe), 64'd0);
         if (busy) begin
            checkOutput("we_busy", 64'(macWe), 64'd0);
            if (wrQ.size() > 0) checkOutput("sel_stall", 64'(macSel), 64'(wrQ[0].sel));
         end
         if (ceR && en && macWe) begin
            checkOutput("write_queued", 64'(wrQ.size() > 0), 64'd1);
            if (wrQ.size() > 0) begin
               monE = wrQ.pop_front();
               checkOutput("wr_sel", 64'(macSel), 64'(monE.sel));
               checkOutput("wr_op", 64'(macOp), 64'(monE.op));
               checkOutput("wr_s", 64'(macS), 64'(monE.s));
               checkOutput("wr_a", 64'(macA), 64'(monE.a));
               checkOutput("wr_do", 64'(macDo), 64'(monE.d));
               modelWrite(macSel, macOp, macA, macDo);
            end
         end
      end
   end

   task automatic applyStimulus(input string tag, input logic [3:0] o, input logic s, input logic [1:0] d,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] aa,
                                input logic [31:0] ab, input int expLat, input logic isRead,
                                input logic [31:0] expRd);
      int n;
      logic got;
      logic [31:0] e;
      @(negedge clock);
      op = o;
      sat = s;
      dst = d;
      opa = a0;
      opb = b0;
      addrA = aa;
      addrB = ab;
      req = 1'b1;
      if (isRead) rdQ.push_back(expRd);
      n = 0;
      got = 1'b0;
      while (!got && n < 50) begin
         @(negedge clock);
         n++;
         got = ack;
      end
      checkOutput({tag, "_ack_latency"}, got ? 64'(n) : 64'hFFFF_FFFF, 64'(expLat));
      if (isRead) begin
         e = rdQ.pop_front();
         checkOutput({tag, "_rdata"}, 64'(rdata), 64'(e));
         lastRd = e;
      end else begin
         checkOutput({tag, "_rdata_hold"}, 64'(rdata), 64'(lastRd));
      end
      req = 1'b0;
      @(negedge clock);
      checkOutput({tag, "_ack_strobe"}, 64'(ack), 64'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ack"}, 64'(ack), 64'd0);
      checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
      checkOutput({tag, "_sel"}, 64'(macSel), 64'd0);
      checkOutput({tag, "_op"}, 64'(macOp), 64'd0);
      checkOutput({tag, "_s"}, 64'(macS), 64'd0);
      checkOutput({tag, "_we"}, 64'(macWe), 64'd0);
      checkOutput({tag, "_a"}, 64'(macA), 64'd0);
      checkOutput({tag, "_do"}, 64'(macDo), 64'd0);
   endtask

   initial begin
      int n;
      logic found;

      repeat (2) @(negedge clock);
      checkAllZero("reset");
      rstN = 1'b1;
      @(negedge clock);

      pushWrite(2'b10, 4'h4, 1'b0, 32'h0, 32'hDEADBEEF);
      applyStimulus("lds_mach", 4'h4, 1'b0, 2'b10, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 2, 1'b0, 32'h0);

      pushWrite(2'b10, 4'h7, 1'b0, 32'h0, 32'h0003FFFE);
      applyStimulus("muls_w", 4'h7, 1'b0, 2'b00, 32'h0000FFFE, 32'h00000003, 32'h0, 32'h0, 2, 1'b0, 32'h0);

      busySel = 2'b01;
      busyLeft = 1;
      applyStimulus("sts_macl_busy", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 3, 1'b1, 32'hFFFFFFFA);

      pushWrite(2'b01, 4'h3, 1'b0, 32'h0, 32'h80000000);
      pushWrite(2'b10, 4'h3, 1'b0, 32'h0, 32'h00000002);
      applyStimulus("dmuls", 4'h3, 1'b0, 2'b00, 32'h80000000, 32'h00000002, 32'h0, 32'h0, 3, 1'b0, 32'h0);
      applyStimulus("sts_mach_dmuls", 4'h0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'hFFFFFFFF);
      applyStimulus("sts_macl_dmuls", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h00000000);

      pushWrite(2'b01, 4'hF, 1'b0, 32'h0, 32'h0);
      applyStimulus("clrmac", 4'hF, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b0, 32'h0);

      pushWrite(2'b01, 4'hB, 1'b0, 32'h00001002, 32'h12340004);
      pushWrite(2'b10, 4'hB, 1'b0, 32'h00002000, 32'h00059999);
      applyStimulus("mac_w", 4'hB, 1'b0, 2'b00, 32'h12340004, 32'h00059999, 32'h00001002, 32'h00002000, 3, 1'b0, 32'h0);
      applyStimulus("sts_macl_macw", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h00000014);

      pushWrite(2'b01, 4'h9, 1'b1, 32'h00000100, 32'h00000003);
      pushWrite(2'b10, 4'h9, 1'b1, 32'h00000200, 32'h00000005);
      applyStimulus("mac_l_sat", 4'h9, 1'b1, 2'b00, 32'h3, 32'h5, 32'h00000100, 32'h00000200, 3, 1'b0, 32'h0);
      applyStimulus("sts_macl_macl", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h00000023);
      applyStimulus("sts_mach_macl", 4'h0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h00000000);

      busySel = 2'b01;
      busyLeft = 3;
      pushWrite(2'b01, 4'h2, 1'b0, 32'h0, 32'hFFFFFFFF);
      pushWrite(2'b10, 4'h2, 1'b0, 32'h0, 32'h00000002);
      applyStimulus("dmulu_stall", 4'h2, 1'b0, 2'b00, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 6, 1'b0, 32'h0);
      applyStimulus("sts_mach_dmulu", 4'h0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h00000001);
      applyStimulus("sts_macl_dmulu", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'hFFFFFFFE);

      enSel = 2'b01;
      enLowLeft = 2;
      pushWrite(2'b01, 4'h1, 1'b0, 32'h0, 32'h00000007);
      pushWrite(2'b10, 4'h1, 1'b0, 32'h0, 32'h00000006);
      applyStimulus("mull_en_low", 4'h1, 1'b0, 2'b00, 32'h7, 32'h6, 32'h0, 32'h0, 5, 1'b0, 32'h0);
      applyStimulus("sts_macl_mull", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h0000002A);

      ceSel = 2'b10;
      ceLowLeft = 2;
      pushWrite(2'b10, 4'h6, 1'b0, 32'h0, 32'h0002FFFF);
      applyStimulus("muluw_ce_low", 4'h6, 1'b0, 2'b00, 32'h0000FFFF, 32'h00000002, 32'h0, 32'h0, 4, 1'b0, 32'h0);
      applyStimulus("sts_macl_muluw", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h0001FFFE);

      applyStimulus("unlisted_op", 4'h5, 1'b0, 2'b00, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0, 1, 1'b0, 32'h0);

      pushWrite(2'b01, 4'h1, 1'b0, 32'h0, 32'h11111111);
      @(negedge clock);
      op = 4'h1;
      sat = 1'b0;
      dst = 2'b00;
      opa = 32'h11111111;
      opb = 32'h00000003;
      addrA = '0;
      addrB = '0;
      req = 1'b1;
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         @(negedge clock);
         n++;
         found = (macSel == 2'b10);
      end
      checkOutput("rst_reached_wr_b", 64'(found), 64'd1);
      rstN = 1'b0;
      #2;
      checkAllZero("mid_reset");
      req = 1'b0;
      @(negedge clock);
      rstN = 1'b1;
      lastRd = '0;

      pushWrite(2'b01, 4'h4, 1'b0, 32'h0, 32'h55AA55AA);
      applyStimulus("lds_macl_after_rst", 4'h4, 1'b0, 2'b01, 32'h55AA55AA, 32'h0, 32'h0, 32'h0, 2, 1'b0, 32'h0);
      applyStimulus("sts_macl_after_rst", 4'h0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1, 32'h55AA55AA);

      checkOutput("wr_queue_empty", 64'(wrQ.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
